mixer_ctrl_avalon_slave: RTL and testbench

- Avalon-MM slave register file that acts as the responder to the mixer configuration master.
- Holds the global mixer control word and per-layer X/Y offset and enable registers.
- Layer writes land in shadow registers. They become active only on a frame_start pulse, so a layer never changes mid-frame.
- Sits between the Avalon interconnect and the mixer datapath. It also serves as a bench stand-in for the VIP mixer slave.

---
 rtl/mixer_ctrl_avalon_slave_pkg.sv | 25 ++
 rtl/mixer_ctrl_avalon_slave_if.sv | 20 ++
 rtl/mixer_ctrl_avalon_slave_read_pipe.sv | 29 ++
 rtl/mixer_ctrl_avalon_slave.sv | 108 ++++++++++
 tb/tb_mixer_ctrl_avalon_slave.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mixer_ctrl_avalon_slave_pkg.sv
// mixer_ctrl_pkg: register map addresses, STATUS bit indices, layer register type and byte-merge helpers
package mixer_ctrl_pkg;
  localparam logic [4:0] ADDR_CONTROL = 5'd0;
  localparam logic [4:0] ADDR_STATUS = 5'd1;
  localparam logic [4:0] ADDR_LAYERS = 5'd2;
  localparam int LAYER_BASE = 8;
  localparam int LAYER_STRIDE = 5;
  localparam int OFF_X = 0;
  localparam int OFF_Y = 1;
  localparam int OFF_CTRL = 2;
  localparam int ST_GO = 0;
  localparam int ST_PENDING = 1;
  localparam int ST_BURST_ERR = 2;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic en;
  } layer_regs_t;
  function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] wd, input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction
  function automatic logic [4:0] layer_addr(input int n, input int off);
    return 5'(LAYER_BASE + LAYER_STRIDE * n + off);
  endfunction
endpackage

// File: rtl/mixer_ctrl_avalon_slave_if.sv
// mixer_ctrl_avalon_slave_if: Avalon-MM bus (address/read/write/writedata/byteenable/burstcount -> waitrequest/readdata/readdatavalid) with master/slave modports
interface mixer_ctrl_avalon_slave_if;
  logic [31:0] address;
  logic read;
  logic write;
  logic [31:0] writedata;
  logic [3:0] byteenable;
  logic [10:0] burstcount;
  logic waitrequest;
  logic [31:0] readdata;
  logic readdatavalid;
  modport master(
    output address, read, write, writedata, byteenable, burstcount,
    input waitrequest, readdata, readdatavalid
  );
  modport slave(
    input address, read, write, writedata, byteenable, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mixer_ctrl_avalon_slave_read_pipe.sv
// mixer_ctrl_read_pipe: LATENCY-deep read data/valid delay line (clk, reset, in_valid/in_data -> out_valid/out_data)
module mixer_ctrl_read_pipe #(
  parameter int LATENCY = 2,
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0] dat [LATENCY];
  always_ff @(posedge clk)
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  assign out_valid = vld[LATENCY-1];
  assign out_data = dat[LATENCY-1];
endmodule

// File: rtl/mixer_ctrl_avalon_slave.sv
// mixer_ctrl_avalon_slave: Avalon-MM mixer control regs (clk, reset, avs_s0 bus, frame_start -> go, layer_x/y_offset, layer_enable, commit_pulse) with frame-aligned shadow commit
import mixer_ctrl_pkg::*;
module mixer_ctrl_avalon_slave #(
  parameter int NUM_LAYERS = 2,
  parameter int WAIT_CYCLES = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  mixer_ctrl_avalon_slave_if.slave avs_s0,
  input  logic frame_start,
  output logic go,
  output logic [NUM_LAYERS*16-1:0] layer_x_offset,
  output logic [NUM_LAYERS*16-1:0] layer_y_offset,
  output logic [NUM_LAYERS-1:0] layer_enable,
  output logic commit_pulse
);
  logic [2:0] wcnt;
  logic wait_req, req, accept, burst_bad, addr_ok, wr_ok, rd_acc, layer_wr, burst_clr;
  logic go_req, commit_pending, burst_err;
  logic [4:0] addr;
  logic [31:0] rd_data;
  layer_regs_t [NUM_LAYERS-1:0] shadow, shadow_nxt, active;
  logic unused_bits;
  assign unused_bits = ^{avs_s0.writedata[31:16], avs_s0.byteenable[3:2]};
  // stall depends only on the counter, so there is no combinational read/write -> waitrequest path
  assign wait_req = wcnt < 3'(WAIT_CYCLES);
  assign avs_s0.waitrequest = wait_req;
  assign req = avs_s0.read | avs_s0.write;
  assign accept = req & ~wait_req;
  assign burst_bad = avs_s0.burstcount != 11'd1;
  assign addr_ok = avs_s0.address[31:5] == '0;
  assign addr = avs_s0.address[4:0];
  assign wr_ok = accept & avs_s0.write & ~burst_bad & addr_ok;
  // read+write together is treated as a write
  assign rd_acc = accept & avs_s0.read & ~avs_s0.write;
  assign burst_clr = wr_ok & addr == ADDR_STATUS & avs_s0.byteenable[0] & avs_s0.writedata[ST_BURST_ERR];
  always_comb begin
    shadow_nxt = shadow;
    layer_wr = 1'b0;
    for (int n = 0; n < NUM_LAYERS; n++) begin
      if (wr_ok && addr == layer_addr(n, OFF_X))
        shadow_nxt[n].x = merge16(shadow[n].x, avs_s0.writedata[15:0], avs_s0.byteenable[1:0]);
      if (wr_ok && addr == layer_addr(n, OFF_Y))
        shadow_nxt[n].y = merge16(shadow[n].y, avs_s0.writedata[15:0], avs_s0.byteenable[1:0]);
      if (wr_ok && addr == layer_addr(n, OFF_CTRL) && avs_s0.byteenable[0])
        shadow_nxt[n].en = avs_s0.writedata[0];
      layer_wr = layer_wr | (wr_ok && addr >= layer_addr(n, OFF_X) && addr <= layer_addr(n, OFF_CTRL));
    end
  end
  // layer reads return the shadow copy; a burst read returns zero
  always_comb begin
    rd_data = '0;
    if (addr_ok && !burst_bad) begin
      if (addr == ADDR_CONTROL) rd_data[0] = go_req;
      if (addr == ADDR_STATUS) begin
        rd_data[ST_GO] = go;
        rd_data[ST_PENDING] = commit_pending;
        rd_data[ST_BURST_ERR] = burst_err;
      end
      if (addr == ADDR_LAYERS) rd_data = 32'(NUM_LAYERS);
      for (int n = 0; n < NUM_LAYERS; n++) begin
        if (addr == layer_addr(n, OFF_X)) rd_data[15:0] = shadow[n].x;
        if (addr == layer_addr(n, OFF_Y)) rd_data[15:0] = shadow[n].y;
        if (addr == layer_addr(n, OFF_CTRL)) rd_data[0] = shadow[n].en;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      wcnt <= '0;
      go_req <= 1'b0;
      go <= 1'b0;
      commit_pending <= 1'b0;
      commit_pulse <= 1'b0;
      burst_err <= 1'b0;
      shadow <= '0;
      active <= '0;
    end else begin
      wcnt <= (req && wait_req) ? wcnt + 3'd1 : 3'd0;
      if (wr_ok && addr == ADDR_CONTROL && avs_s0.byteenable[0]) go_req <= avs_s0.writedata[0];
      burst_err <= (accept & burst_bad) | (burst_err & ~burst_clr);
      shadow <= shadow_nxt;
      // a layer write coinciding with frame_start keeps the pending flag for the next frame
      commit_pending <= layer_wr | (commit_pending & ~frame_start);
      commit_pulse <= frame_start & commit_pending;
      if (frame_start) go <= go_req;
      if (frame_start && commit_pending) active <= shadow;
    end
  always_comb begin
    layer_x_offset = '0;
    layer_y_offset = '0;
    layer_enable = '0;
    for (int n = 0; n < NUM_LAYERS; n++) begin
      layer_x_offset[16*n +: 16] = active[n].x;
      layer_y_offset[16*n +: 16] = active[n].y;
      layer_enable[n] = active[n].en;
    end
  end
  mixer_ctrl_read_pipe #(.LATENCY(READ_LATENCY), .WIDTH(32)) u_read_pipe (
    .clk(clk),
    .reset(reset),
    .in_valid(rd_acc),
    .in_data(rd_data),
    .out_valid(avs_s0.readdatavalid),
    .out_data(avs_s0.readdata)
  );
endmodule

// File: tb/tb_mixer_ctrl_avalon_slave.sv
// tb_mixer_ctrl_avalon_slave: directed self-checking bench for mixer_ctrl_avalon_slave (2 layers, 2 wait cycles, read latency 2)
module tb_mixer_ctrl_avalon_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic go, commit_pulse;
  logic [31:0] lx, ly;
  logic [1:0] len;
  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int nreads = 0;
  logic [31:0] rq[$];
  mixer_ctrl_avalon_slave_if avs();
  mixer_ctrl_avalon_slave #(.NUM_LAYERS(2), .WAIT_CYCLES(2), .READ_LATENCY(2)) dut (
    .clk(clk),
    .reset(reset),
    .avs_s0(avs),
    .frame_start(frame_start),
    .go(go),
    .layer_x_offset(lx),
    .layer_y_offset(ly),
    .layer_enable(len),
    .commit_pulse(commit_pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (avs.readdatavalid) begin
      rq.push_back(avs.readdata);
      nvalid++;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic access(input bit rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [10:0] bc, input bit hold, input bit fs, output int waits);
    avs.address = a;
    avs.read = rd;
    avs.write = !rd;
    avs.writedata = d;
    avs.byteenable = be;
    avs.burstcount = bc;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!avs.waitrequest || waits == 16) break;
      waits++;
    end
    if (waits == 16) chk("accept_timeout", 32'(waits), 32'd2);
    if (rd) nreads++;
    frame_start = fs;
    @(posedge clk); #1;
    frame_start = 1'b0;
    if (!hold) begin
      avs.read = 1'b0;
      avs.write = 1'b0;
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [10:0] bc, input bit fs);
    int w;
    access(1'b0, a, d, be, bc, 1'b0, fs, w);
  endtask
  task automatic pop(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 10 && rq.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    if (rq.size() == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk(tag, rq.pop_front(), exp);
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [10:0] bc, input logic [31:0] exp);
    int w;
    access(1'b1, a, 32'd0, 4'hf, bc, 1'b0, 1'b0, w);
    pop(tag, exp);
  endtask
  task automatic frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int w;
    avs.address = '0;
    avs.read = 1'b0;
    avs.write = 1'b0;
    avs.writedata = '0;
    avs.byteenable = '0;
    avs.burstcount = 11'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", avs.waitrequest, 1);
    chk("rst_go", go, 0);
    chk("rst_commit_pulse", commit_pulse, 0);
    chk("rst_x", lx, 0);
    chk("rst_en", len, 0);
    chk("rst_rdvalid", avs.readdatavalid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wr(32'd8, 32'h10, 4'hf, 11'd1, 1'b0);
    wr(32'd9, 32'h20, 4'hf, 11'd1, 1'b0);
    wr(32'd10, 32'h1, 4'hf, 11'd1, 1'b0);
    access(1'b1, 32'd1, 32'd0, 4'hf, 11'd1, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("rd_lat_early", avs.readdatavalid, 0);
    @(negedge clk);
    chk("rd_lat_valid", avs.readdatavalid, 1);
    @(posedge clk); #1;
    chk("rd_lat_single", avs.readdatavalid, 0);
    pop("status_pending", 32'h2);
    chk("x_before_commit", lx[15:0], 0);
    frame();
    chk("commit_pulse_hi", commit_pulse, 1);
    chk("x0_active", lx[15:0], 32'h10);
    chk("y0_active", ly[15:0], 32'h20);
    chk("en_active", len, 2'b01);
    @(posedge clk); #1;
    chk("commit_pulse_lo", commit_pulse, 0);
    rd("status_committed", 32'd1, 11'd1, 32'h0);
    access(1'b0, 32'd0, 32'h1, 4'hf, 11'd1, 1'b0, 1'b0, w);
    chk("go_wait_cycles", 32'(w), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("go_before_frame", go, 0);
    frame();
    chk("go_after_frame", go, 1);
    chk("no_commit_pulse", commit_pulse, 0);
    rd("ctrl_readback", 32'd0, 11'd1, 32'h1);
    wr(32'd13, 32'hFFFF_FFFF, 4'b0001, 11'd1, 1'b0);
    rd("be_x1", 32'd13, 11'd1, 32'h0000_00FF);
    rd("status_pending2", 32'd1, 11'd1, 32'h3);
    access(1'b1, 32'd2, 32'd0, 4'hf, 11'd1, 1'b1, 1'b0, w);
    access(1'b1, 32'd8, 32'd0, 4'hf, 11'd1, 1'b1, 1'b0, w);
    access(1'b1, 32'h40, 32'd0, 4'hf, 11'd1, 1'b0, 1'b0, w);
    pop("b2b_layers", 32'h2);
    pop("b2b_shadow_x", 32'h10);
    pop("b2b_unmapped", 32'h0);
    rd("high_addr_bits", 32'h28, 11'd1, 32'h0);
    wr(32'd8, 32'h1234, 4'hf, 11'd4, 1'b0);
    rd("burst_wr_dropped", 32'd8, 11'd1, 32'h10);
    rd("status_burst_err", 32'd1, 11'd1, 32'h7);
    rd("burst_rd_zero", 32'd2, 11'd2, 32'h0);
    wr(32'd1, 32'h4, 4'hf, 11'd1, 1'b0);
    rd("status_w1c", 32'd1, 11'd1, 32'h3);
    frame();
    chk("x1_committed", lx[31:16], 32'hFF);
    chk("x1_commit_pulse", commit_pulse, 1);
    rd("status_after_commit", 32'd1, 11'd1, 32'h1);
    wr(32'd9, 32'h30, 4'hf, 11'd1, 1'b0);
    wr(32'd8, 32'h55, 4'hf, 11'd1, 1'b1);
    chk("sim_x_old", lx[15:0], 32'h10);
    chk("sim_y_prewrite", ly[15:0], 32'h30);
    chk("sim_pulse", commit_pulse, 1);
    rd("sim_status_pending", 32'd1, 11'd1, 32'h3);
    frame();
    chk("sim_x_new", lx[15:0], 32'h55);
    access(1'b1, 32'd2, 32'd0, 4'hf, 11'd1, 1'b0, 1'b0, w);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_queue", 32'(rq.size()), 32'd0);
    chk("valid_count", 32'(nvalid), 32'(nreads - 1));
    chk("rst2_x", lx, 0);
    chk("rst2_go", go, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
